mu0_state_sequencer: RTL and testbench



---
 rtl/mu0_state_sequencer.sv | 132 +++++++++++++
 tb/tb_mu0_state_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mu0_state_sequencer.sv
// MU0 control sequencer: one-hot Fetch/Exec1/Exec2 strobes, extension-unit wait with watchdog.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_COUNT_EN.
module mu0_state_sequencer #(
    parameter int EXT_TIMEOUT = 255,
    parameter int TW          = 8,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Run,
    input  logic             Halt_Req,
    input  logic [3:0]       op,
    input  logic             Ext_Done,
    output logic             Fetch,
    output logic             Exec1,
    output logic             Exec2,
    output logic             Ext_Start,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] Instr_Count,
    output logic [2:0]       seq_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_EXEC1    = 3'd2;
    localparam logic [2:0] S_EXEC2    = 3'd3;
    localparam logic [2:0] S_EXT_WAIT = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    // Timer value during the last permitted EXT_WAIT cycle (timer is 0 in the first).
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(EXT_TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [TW-1:0] timer;
    logic          pending;
    logic          retire;
    logic          set_fault;
    logic          halt_now;
    logic          stopped;
    logic          active;

    assign stopped  = (state == S_IDLE) || (state == S_HALT);
    assign active   = (state == S_FETCH) || (state == S_EXEC1) ||
                      (state == S_EXEC2) || (state == S_EXT_WAIT);
    // A request arriving in the retiring cycle itself still takes effect.
    assign halt_now = pending || Halt_Req;

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        set_fault  = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (Run) state_next = S_FETCH;
            end
            S_FETCH: state_next = S_EXEC1;
            S_EXEC1: begin
                case (op)
                    4'b0000, 4'b0010, 4'b0011: state_next = S_EXEC2;
                    4'b1100, 4'b1101, 4'b1110: state_next = S_EXT_WAIT;
                    4'b0111: begin
                        state_next = S_HALT;
                        retire     = 1'b1;
                    end
                    4'b1011, 4'b1111: begin
                        state_next = S_HALT;
                        set_fault  = 1'b1;
                    end
                    default: begin
                        retire     = 1'b1;
                        state_next = halt_now ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_EXEC2: begin
                retire     = 1'b1;
                state_next = halt_now ? S_HALT : S_FETCH;
            end
            S_EXT_WAIT: begin
                if (Ext_Done) begin
                    retire     = 1'b1;
                    state_next = halt_now ? S_HALT : S_FETCH;
                end else if (timer == TIMEOUT_LAST) begin
                    state_next = S_HALT;
                    set_fault  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            pending <= 1'b0;
            Fault   <= 1'b0;
        end else begin
            state <= state_next;
            // Timer is held at zero outside EXT_WAIT, so it reads 0 on entry.
            if (state == S_EXT_WAIT) timer <= timer + 1'b1;
            else                     timer <= '0;

            if (state_next == S_HALT || (stopped && Run)) pending <= 1'b0;
            else if (active && Halt_Req)                   pending <= 1'b1;

            if (stopped && Run)  Fault <= 1'b0;
            else if (set_fault)  Fault <= 1'b1;
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)      Instr_Count <= '0;
        else if (retire) Instr_Count <= Instr_Count + 1'b1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign Instr_Count   = '0;
`endif

    assign Fetch     = (state == S_FETCH);
    assign Exec1     = (state == S_EXEC1);
    assign Exec2     = (state == S_EXEC2);
    assign Ext_Start = (state == S_EXT_WAIT) && (timer == '0);
    assign Halted    = stopped;
    assign seq_state = state;

endmodule

// File: tb/tb_mu0_state_sequencer.sv
// Vector-table bench for mu0_state_sequencer (EXT_TIMEOUT=4); counter expectations follow SEQ_INSTR_COUNT_EN.
module tb_mu0_state_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Run;
    logic        Halt_Req;
    logic [3:0]  op;
    logic        Ext_Done;
    logic        Fetch, Exec1, Exec2, Ext_Start, Halted, Fault;
    logic [15:0] Instr_Count;
    logic [2:0]  seq_state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       run;
        logic       hreq;
        logic [3:0] op;
        logic       done;
        logic [5:0] exp_out;   // {Fetch,Exec1,Exec2,Ext_Start,Halted,Fault}
        int         exp_cnt;
    } vec_t;

    vec_t vq[$];

    mu0_state_sequencer #(.EXT_TIMEOUT(4), .TW(8), .CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Halt_Req(Halt_Req), .op(op),
        .Ext_Done(Ext_Done), .Fetch(Fetch), .Exec1(Exec1), .Exec2(Exec2),
        .Ext_Start(Ext_Start), .Halted(Halted), .Fault(Fault),
        .Instr_Count(Instr_Count), .seq_state(seq_state)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] ec(input int c);
`ifdef SEQ_INSTR_COUNT_EN
        return 16'(c);
`else
        return 16'(c * 0);
`endif
    endfunction

    task automatic add(input logic r, input logic h, input logic [3:0] o, input logic d,
                       input logic [5:0] e, input int c);
        vec_t v;
        v.run = r; v.hreq = h; v.op = o; v.done = d; v.exp_out = e; v.exp_cnt = c;
        vq.push_back(v);
    endtask

    task automatic check_out(input string name, input logic [5:0] exp_o, input int c);
        logic [5:0] act;
        act = {Fetch, Exec1, Exec2, Ext_Start, Halted, Fault};
        n_cmp++;
        if (act !== exp_o) begin
            n_bad++;
            $display("FAIL %s outputs {F,E1,E2,XS,H,FLT} got %b want %b", name, act, exp_o);
        end
        n_cmp++;
        if (Instr_Count !== ec(c)) begin
            n_bad++;
            $display("FAIL %s Instr_Count got %0d want %0d", name, Instr_Count, ec(c));
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic [3:0] o, input logic d);
        Run = r; Halt_Req = h; op = o; Ext_Done = d;
    endtask

    initial begin
        //        run h  op       done  F E1 E2 XS H FLT   cnt
        add(1, 0, 4'b0001, 0, 6'b100000, 0);  // Run -> FETCH
        add(0, 0, 4'b0001, 0, 6'b010000, 0);
        add(0, 0, 4'b0001, 0, 6'b100000, 1);  // single-exec retire
        add(0, 0, 4'b0111, 0, 6'b010000, 1);
        add(0, 0, 4'b0111, 0, 6'b000010, 2);  // STP retires, halts
        add(0, 0, 4'b0000, 0, 6'b000010, 2);
        add(1, 0, 4'b0010, 0, 6'b100000, 2);
        add(0, 0, 4'b0010, 0, 6'b010000, 2);
        add(0, 0, 4'b0010, 0, 6'b001000, 2);  // ADD -> EXEC2
        add(0, 0, 4'b1101, 0, 6'b100000, 3);
        add(0, 0, 4'b1101, 0, 6'b010000, 3);
        add(0, 0, 4'b1101, 0, 6'b000100, 3);  // EXT_WAIT cycle 1, Ext_Start
        add(0, 0, 4'b1101, 0, 6'b000000, 3);
        add(0, 0, 4'b1101, 0, 6'b000000, 3);
        add(0, 0, 4'b1101, 0, 6'b000000, 3);  // cycle 4 = timeout cycle
        add(0, 0, 4'b1101, 1, 6'b100000, 4);  // done wins over timeout
        add(0, 0, 4'b1100, 0, 6'b010000, 4);
        add(0, 0, 4'b1100, 0, 6'b000100, 4);
        add(0, 0, 4'b1100, 0, 6'b000000, 4);
        add(0, 0, 4'b1100, 0, 6'b000000, 4);
        add(0, 0, 4'b1100, 0, 6'b000000, 4);
        add(0, 0, 4'b1100, 0, 6'b000011, 4);  // watchdog fault, no retire
        add(1, 0, 4'b0010, 0, 6'b100000, 4);  // Run clears Fault
        add(0, 1, 4'b0010, 0, 6'b010000, 4);  // Halt_Req in FETCH
        add(0, 0, 4'b0010, 0, 6'b001000, 4);
        add(0, 0, 4'b0010, 0, 6'b000010, 5);  // halt at EXEC2 retire
        add(1, 0, 4'b0001, 0, 6'b100000, 5);
        add(0, 0, 4'b0001, 0, 6'b010000, 5);
        add(0, 0, 4'b0001, 0, 6'b100000, 6);  // pending was cleared
        add(0, 0, 4'b1111, 0, 6'b010000, 6);
        add(0, 0, 4'b1111, 0, 6'b000011, 6);  // undefined op fault
        add(1, 0, 4'b0001, 0, 6'b100000, 6);
        add(0, 0, 4'b0001, 0, 6'b010000, 6);
        add(0, 1, 4'b0001, 0, 6'b000010, 7);  // Halt_Req same cycle as retire
        add(1, 0, 4'b1011, 0, 6'b100000, 7);
        add(0, 0, 4'b1011, 1, 6'b010000, 7);  // Ext_Done ignored in FETCH
        add(0, 0, 4'b1011, 0, 6'b000011, 7);  // 1011 fault
        add(0, 1, 4'b1011, 0, 6'b000011, 7);  // Halt_Req ignored in HALT
        add(1, 0, 4'b1100, 0, 6'b100000, 7);
        add(0, 0, 4'b1100, 0, 6'b010000, 7);
        add(0, 0, 4'b1100, 0, 6'b000100, 7);
        add(0, 1, 4'b1100, 1, 6'b000010, 8);  // done in first cycle + halt
        add(1, 0, 4'b1110, 0, 6'b100000, 8);
        add(0, 0, 4'b1110, 0, 6'b010000, 8);
        add(0, 0, 4'b1110, 0, 6'b000100, 8);
        add(0, 0, 4'b1110, 0, 6'b000000, 8);  // mid EXT_WAIT

        drive(0, 0, 4'b0000, 0);
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_out("reset", 6'b000010, 0);
        Rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].run, vq[i].hreq, vq[i].op, vq[i].done);
            @(posedge Clk);
            #1;
            check_out($sformatf("vec%0d", i), vq[i].exp_out, vq[i].exp_cnt);
        end

        // Asynchronous reset while in EXT_WAIT takes effect without a clock edge.
        drive(0, 0, 4'b1110, 0);
        Rst_n = 1'b0;
        #1;
        check_out("async_reset", 6'b000010, 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check_out("idle_no_run", 6'b000010, 0);

        // Run into an STP and wait, bounded, for Halted.
        drive(1, 0, 4'b0111, 0);
        @(posedge Clk);
        #1;
        check_out("run_stp", 6'b100000, 0);
        drive(0, 0, 4'b0111, 0);
        begin
            int k;
            k = 0;
            while (!Halted && k < 10) begin
                @(posedge Clk);
                #1;
                k++;
            end
            n_cmp++;
            if (k != 2) begin
                n_bad++;
                $display("FAIL stp_latency cycles got %0d want 2", k);
            end
        end
        check_out("stp_halted", 6'b000010, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
